musb_fetch_unit: RTL and testbench

- Instruction-fetch control stage of the MUSB pipeline. It sits between the PC register and the ID stage.
- Takes `if_pc` and runs a request/ready transaction on the instruction memory port.
- Generates `if_stall` back to the PC register.
- Owns the IF/ID pipeline register, including a one-entry skid buffer for a response that arrives while ID is stalled.

---
 rtl/musb_fetch_unit_pkg.sv | 29 ++
 rtl/musb_fetch_unit_ifid_register.sv | 32 +++
 rtl/musb_fetch_unit.sv | 138 +++++++++++++
 tb/tb_musb_fetch_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/musb_fetch_unit_pkg.sv
// Shared types and constants for the MUSB instruction-fetch stage.
package musb_fetch_unit_pkg;

    // Instruction word used for pipeline bubbles.
    localparam logic [31:0] MUSB_NOP = 32'h0000_0000;

    // Fetch FSM encodings.
    typedef enum logic [1:0] {
        MUSB_IF_FETCH   = 2'd0,
        MUSB_IF_DISCARD = 2'd1,
        MUSB_IF_HOLD    = 2'd2
    } if_state_e;

    // One IF/ID entry; the skid buffer uses the same layout.
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] pc_add4;
        logic        valid;
        logic        exc_if_addr;
        logic        exc_if_bus;
    } ifid_t;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_add4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/musb_fetch_unit_ifid_register.sv
// IF/ID pipeline register: holds while stalled, loads an entry or a bubble otherwise.
module musb_ifid_register
    import musb_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = MUSB_NOP
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  load,
    input  ifid_t d,
    output ifid_t q
);

    // Stall wins over everything; a cycle with no delivery becomes a bubble.
    // The bubble keeps the last PC fields so debug views stay meaningful.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '{instruction: NOP_INSTR, default: '0};
        end else if (!stall) begin
            if (load) begin
                q <= d;
            end else begin
                q.instruction <= NOP_INSTR;
                q.valid       <= 1'b0;
                q.exc_if_addr <= 1'b0;
                q.exc_if_bus  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/musb_fetch_unit.sv
// Instruction-fetch control: memory handshake, PC stall, skid buffer, IF/ID.
module musb_fetch_unit
    import musb_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = MUSB_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        if_flush,
    input  logic        id_stall,
    output logic        if_stall,
    output logic [31:0] imem_addr,
    output logic        imem_rd,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    input  logic        imem_error,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_add4,
    output logic        id_valid,
    output logic        id_exc_if_addr,
    output logic        id_exc_if_bus
);

    if_state_e   state, next_state;
    logic [31:0] req_addr;
    ifid_t       buf_q;
    ifid_t       fetch_entry;
    ifid_t       ifid_d;
    ifid_t       ifid_q;
    logic        misaligned;
    logic        resp;
    logic        ifid_load;
    logic        buf_load;

    assign misaligned = |if_pc[1:0];

    // Entry built from the current fetch; a misaligned PC stands in for a response.
    always_comb begin
        fetch_entry.instruction = misaligned ? NOP_INSTR : imem_data;
        fetch_entry.pc          = if_pc;
        fetch_entry.pc_add4     = pc_add4(if_pc);
        fetch_entry.valid       = !misaligned && !imem_error;
        fetch_entry.exc_if_addr = misaligned;
        fetch_entry.exc_if_bus  = !misaligned && imem_error;
    end

    // Fetch FSM next-state and handshake outputs.
    always_comb begin
        next_state = state;
        imem_rd    = 1'b0;
        imem_addr  = if_pc;
        if_stall   = 1'b1;
        resp       = 1'b0;
        ifid_load  = 1'b0;
        buf_load   = 1'b0;
        ifid_d     = fetch_entry;
        case (state)
            MUSB_IF_FETCH: begin
                imem_rd = !misaligned;
                resp    = misaligned || imem_ready;
                if (if_flush) begin
                    // Let the PC take the target; an in-flight request must still drain.
                    if_stall = 1'b0;
                    if (!resp) next_state = MUSB_IF_DISCARD;
                end else if (resp) begin
                    if (id_stall) begin
                        buf_load   = 1'b1;
                        next_state = MUSB_IF_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        if_stall  = 1'b0;
                    end
                end
            end
            MUSB_IF_DISCARD: begin
                // Bus requests are never aborted: keep the old address until ready.
                imem_rd   = 1'b1;
                imem_addr = req_addr;
                if_stall  = !if_flush;
                if (imem_ready) next_state = MUSB_IF_FETCH;
            end
            MUSB_IF_HOLD: begin
                imem_addr = req_addr;
                if (if_flush) begin
                    if_stall   = 1'b0;
                    next_state = MUSB_IF_FETCH;
                end else if (!id_stall) begin
                    ifid_load  = 1'b1;
                    ifid_d     = buf_q;
                    if_stall   = 1'b0;
                    next_state = MUSB_IF_FETCH;
                end
            end
            default: next_state = MUSB_IF_FETCH;
        endcase
        // Quiet the bus and freeze the PC for as long as reset is held.
        if (!rst) begin
            imem_rd  = 1'b0;
            if_stall = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MUSB_IF_FETCH;
        else      state <= next_state;
    end

    // Request address tracking and skid-buffer capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr <= '0;
            buf_q    <= '0;
        end else begin
            if (state == MUSB_IF_FETCH) req_addr <= if_pc;
            if (buf_load)               buf_q    <= fetch_entry;
        end
    end

    musb_ifid_register #(.NOP_INSTR(NOP_INSTR)) u_ifid (
        .clk   (clk),
        .rst   (rst),
        .stall (id_stall),
        .load  (ifid_load),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign id_instruction = ifid_q.instruction;
    assign id_pc          = ifid_q.pc;
    assign id_pc_add4     = ifid_q.pc_add4;
    assign id_valid       = ifid_q.valid;
    assign id_exc_if_addr = ifid_q.exc_if_addr;
    assign id_exc_if_bus  = ifid_q.exc_if_bus;

endmodule

// File: tb/tb_musb_fetch_unit.sv
// Directed bench for musb_fetch_unit with hand-computed expectations.
module tb_musb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_flush;
    logic        id_stall;
    logic        if_stall;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        imem_error;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_add4;
    logic        id_valid;
    logic        id_exc_if_addr;
    logic        id_exc_if_bus;

    int n_chk  = 0;
    int n_pass = 0;

    musb_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_flush       (if_flush),
        .id_stall       (id_stall),
        .if_stall       (if_stall),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .imem_data      (imem_data),
        .imem_ready     (imem_ready),
        .imem_error     (imem_error),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_pc_add4     (id_pc_add4),
        .id_valid       (id_valid),
        .id_exc_if_addr (id_exc_if_addr),
        .id_exc_if_bus  (id_exc_if_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; if_pc = '0; if_flush = 1'b0; id_stall = 1'b0;
        imem_data = '0; imem_ready = 1'b0; imem_error = 1'b0;
        #2;
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instruction, 32'h0);
        chk("rst_rd", {31'd0, imem_rd}, 32'd0);
        chk("rst_stall", {31'd0, if_stall}, 32'd1);
        tick; tick;
        rst = 1'b1;

        // Zero-wait stream
        if_pc = 32'h0; imem_ready = 1'b1; imem_data = 32'h11; #1;
        chk("zw_stall0", {31'd0, if_stall}, 32'd0);
        chk("zw_rd0", {31'd0, imem_rd}, 32'd1);
        tick;
        chk("zw_instr0", id_instruction, 32'h11);
        chk("zw_add4_0", id_pc_add4, 32'h4);
        chk("zw_valid0", {31'd0, id_valid}, 32'd1);
        if_pc = 32'h4; imem_data = 32'h22; #1;
        chk("zw_stall1", {31'd0, if_stall}, 32'd0);
        tick;
        chk("zw_instr1", id_instruction, 32'h22);
        chk("zw_add4_1", id_pc_add4, 32'h8);
        if_pc = 32'h8; imem_data = 32'h33; #1;
        chk("zw_stall2", {31'd0, if_stall}, 32'd0);
        tick;
        chk("zw_instr2", id_instruction, 32'h33);
        chk("zw_add4_2", id_pc_add4, 32'hC);

        // Two wait states
        if_pc = 32'h100; imem_ready = 1'b0; imem_data = '0; #1;
        chk("ws_stall_a", {31'd0, if_stall}, 32'd1);
        chk("ws_addr_a", imem_addr, 32'h100);
        tick;
        chk("ws_bubble", {31'd0, id_valid}, 32'd0);
        #1;
        chk("ws_stall_b", {31'd0, if_stall}, 32'd1);
        chk("ws_addr_b", imem_addr, 32'h100);
        tick;
        imem_ready = 1'b1; imem_data = 32'hABCD; #1;
        chk("ws_stall_c", {31'd0, if_stall}, 32'd0);
        tick;
        chk("ws_instr", id_instruction, 32'hABCD);
        chk("ws_valid", {31'd0, id_valid}, 32'd1);
        chk("ws_pc", id_pc, 32'h100);

        // Skid buffer: response arrives while ID is stalled
        if_pc = 32'h40; imem_data = 32'h55; id_stall = 1'b1; #1;
        chk("sk_stall_cap", {31'd0, if_stall}, 32'd1);
        tick;
        imem_ready = 1'b0; imem_data = '0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("sk_rd", {31'd0, imem_rd}, 32'd0);
            chk("sk_stall", {31'd0, if_stall}, 32'd1);
            chk("sk_hold", id_instruction, 32'hABCD);
            tick;
        end
        id_stall = 1'b0; #1;
        chk("sk_rel_stall", {31'd0, if_stall}, 32'd0);
        tick;
        chk("sk_instr", id_instruction, 32'h55);
        chk("sk_pc", id_pc, 32'h40);
        chk("sk_valid", {31'd0, id_valid}, 32'd1);

        // Flush while a request is pending
        if_pc = 32'h200; #1;
        chk("fl_rd", {31'd0, imem_rd}, 32'd1);
        tick;
        if_flush = 1'b1; #1;
        chk("fl_stall", {31'd0, if_stall}, 32'd0);
        tick;
        if_flush = 1'b0; if_pc = 32'h300; #1;
        chk("fl_addr_hold", imem_addr, 32'h200);
        chk("fl_disc_stall", {31'd0, if_stall}, 32'd1);
        tick;
        imem_ready = 1'b1; imem_data = 32'hDEAD; #1;
        chk("fl_addr_ready", imem_addr, 32'h200);
        tick;
        imem_ready = 1'b0; imem_data = '0;
        chk("fl_dropped", id_instruction, 32'h0);
        chk("fl_valid", {31'd0, id_valid}, 32'd0);
        #1;
        chk("fl_new_addr", imem_addr, 32'h300);
        chk("fl_new_rd", {31'd0, imem_rd}, 32'd1);
        tick;

        // Misaligned fetch
        if_pc = 32'h102; #1;
        chk("ex_a_rd", {31'd0, imem_rd}, 32'd0);
        tick;
        chk("ex_a_tag", {31'd0, id_exc_if_addr}, 32'd1);
        chk("ex_a_valid", {31'd0, id_valid}, 32'd0);
        chk("ex_a_pc", id_pc, 32'h102);

        // Bus error
        if_pc = 32'h104; imem_ready = 1'b1; imem_error = 1'b1; imem_data = 32'h77;
        tick;
        chk("ex_b_tag", {31'd0, id_exc_if_bus}, 32'd1);
        chk("ex_b_valid", {31'd0, id_valid}, 32'd0);
        chk("ex_b_atag", {31'd0, id_exc_if_addr}, 32'd0);

        // PC+4 wraps
        if_pc = 32'hFFFF_FFFC; imem_error = 1'b0; imem_data = 32'h99;
        tick;
        chk("wrap_add4", id_pc_add4, 32'h0);
        chk("wrap_valid", {31'd0, id_valid}, 32'd1);

        // Async reset while in DISCARD
        if_pc = 32'h400; imem_ready = 1'b0; imem_data = '0;
        tick;
        if_flush = 1'b1;
        tick;
        if_flush = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_pc", id_pc, 32'h0);
        chk("ar_add4", id_pc_add4, 32'h0);
        chk("ar_rd", {31'd0, imem_rd}, 32'd0);
        chk("ar_stall", {31'd0, if_stall}, 32'd1);
        tick;
        #2;
        rst = 1'b1;
        if_pc = 32'h500; #1;
        chk("ar_fetch_addr", imem_addr, 32'h500);
        chk("ar_fetch_rd", {31'd0, imem_rd}, 32'd1);
        imem_ready = 1'b1; imem_data = 32'hAA;
        tick;
        chk("ar_instr", id_instruction, 32'hAA);
        imem_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
